// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronise and debounce the seven tank/irrigation field inputs
// Inputs:  clk, rst_n (sync, active-low), raw_h/raw_m/raw_l/raw_ua/raw_us/raw_t/raw_s (asynchronous)
// Outputs: H/M/L/Ua/Us/T/S debounced levels, upd change strobe, level_fault, tick sample strobe
module sensor_conditioner #(
  parameter int TICK_DIV  = 50000,
  parameter int DEB_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_h,
  input  logic raw_m,
  input  logic raw_l,
  input  logic raw_ua,
  input  logic raw_us,
  input  logic raw_t,
  input  logic raw_s,
  output logic H,
  output logic M,
  output logic L,
  output logic Ua,
  output logic Us,
  output logic T,
  output logic S,
  output logic upd,
  output logic level_fault,
  output logic tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = DEB_COUNT > 1 ? $clog2(DEB_COUNT) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEB_COUNT - 1);
  logic [6:0] raw, sync1_q, sync2_q, stable_q, stable_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q [7];
  logic [CW-1:0] cnt_d [7];
  logic upd_q, upd_d, fault_q, fault_d;
  assign raw = {raw_s, raw_t, raw_us, raw_ua, raw_l, raw_m, raw_h};
  // gated by rst_n so no sample strobe is seen while reset is being applied
  assign tick = rst_n && (pre_q == P_MAX);
  always_comb begin
    pre_d = (pre_q == P_MAX) ? '0 : pre_q + 1'b1;
    stable_d = stable_q;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == stable_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == C_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    upd_d = stable_d != stable_q;
    // bit0=H, bit1=M, bit2=L: a higher probe wet while a lower one is dry
    fault_d = (stable_d[0] & ~stable_d[1]) | (stable_d[1] & ~stable_d[2]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      pre_q <= '0;
      cnt_q <= '{default: '0};
      upd_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      upd_q <= upd_d;
      fault_q <= fault_d;
    end
  end
  assign {S, T, Us, Ua, L, M, H} = stable_q;
  assign upd = upd_q;
  assign level_fault = fault_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed checks of sensor_conditioner with TICK_DIV=4, DEB_COUNT=3
module tb_sensor_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_h = 1'b0, raw_m = 1'b0, raw_l = 1'b0, raw_ua = 1'b0, raw_us = 1'b0, raw_t = 1'b0, raw_s = 1'b0;
  logic H, M, L, Ua, Us, T, S, upd, level_fault, tick;
  logic [6:0] outs;
  int errors = 0;
  int checks = 0;
  int nu, nf, nu2, nf2;
  sensor_conditioner #(.TICK_DIV(4), .DEB_COUNT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .raw_h(raw_h), .raw_m(raw_m), .raw_l(raw_l), .raw_ua(raw_ua), .raw_us(raw_us), .raw_t(raw_t), .raw_s(raw_s),
    .H(H), .M(M), .L(L), .Ua(Ua), .Us(Us), .T(T), .S(S),
    .upd(upd), .level_fault(level_fault), .tick(tick)
  );
  assign outs = {S, T, Us, Ua, L, M, H};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, output int cu, output int cf);
    cu = 0;
    cf = 0;
    repeat (n) begin
      step(1);
      cu += int'(upd);
      cf += int'(level_fault);
    end
  endtask
  task automatic set_raw(input logic [6:0] v);
    {raw_s, raw_t, raw_us, raw_ua, raw_l, raw_m, raw_h} = v;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    set_raw(7'h7f);
    do_reset;
    check("rst_outs", outs, 7'h00);
    check("rst_upd", upd, 0);
    check("rst_fault", level_fault, 0);
    check("rst_tick", tick, 0);
    step(2);
    check("tick_cyc3", tick, 0);
    step(1);
    check("tick_cyc4", tick, 1);
    run(8, nu, nf);
    check("all_pre_outs", outs, 7'h00);
    check("all_pre_upd", nu, 0);
    step(1);
    check("all_outs", outs, 7'h7f);
    check("all_upd", upd, 1);
    check("all_fault", level_fault, 0);
    step(1);
    check("all_upd_off", upd, 0);
    set_raw(7'h00);
    do_reset;
    raw_l = 1'b1;
    run(11, nu, nf);
    check("l_pre_outs", outs, 7'h00);
    check("l_pre_upd", nu, 0);
    step(1);
    check("l_outs", outs, 7'h04);
    check("l_upd", upd, 1);
    check("l_fault", level_fault, 0);
    step(1);
    check("l_upd_off", upd, 0);
    raw_m = 1'b1;
    run(8, nu, nf);
    raw_m = 1'b0;
    run(7, nu2, nf2);
    check("glitch_outs", outs, 7'h04);
    check("glitch_upd", nu + nu2, 0);
    raw_m = 1'b1;
    run(11, nu, nf);
    check("m_pre_outs", outs, 7'h04);
    check("m_pre_upd", nu, 0);
    step(1);
    check("m_outs", outs, 7'h06);
    check("m_upd", upd, 1);
    check("m_fault", level_fault, 0);
    set_raw(7'h00);
    do_reset;
    raw_l = 1'b1;
    raw_h = 1'b1;
    run(11, nu, nf);
    check("flt_pre_outs", outs, 7'h00);
    check("flt_pre_fault", nf, 0);
    step(1);
    check("flt_outs", outs, 7'h05);
    check("flt_on", level_fault, 1);
    check("flt_upd", upd, 1);
    raw_m = 1'b1;
    run(11, nu, nf);
    check("flt_hold_outs", outs, 7'h05);
    check("flt_hold", level_fault, 1);
    check("flt_hold_cnt", nf, 11);
    step(1);
    check("flt_clr_outs", outs, 7'h07);
    check("flt_clr", level_fault, 0);
    check("flt_clr_upd", upd, 1);
    set_raw(7'h00);
    do_reset;
    set_raw(7'h07);
    run(11, nu, nf);
    check("sim_pre_outs", outs, 7'h00);
    check("sim_pre_upd", nu, 0);
    check("sim_pre_fault", nf, 0);
    step(1);
    check("sim_outs", outs, 7'h07);
    check("sim_upd", upd, 1);
    check("sim_fault", level_fault, 0);
    run(4, nu, nf);
    check("sim_post_upd", nu, 0);
    check("sim_post_fault", nf, 0);
    set_raw(7'h00);
    do_reset;
    raw_t = 1'b1;
    step(8);
    check("mid_pre_outs", outs, 7'h00);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mid_rst_outs", outs, 7'h00);
    check("mid_rst_tick", tick, 0);
    step(2);
    check("mid_tick_cyc3", tick, 0);
    step(1);
    check("mid_tick_cyc4", tick, 1);
    check("mid_old_sched", outs, 7'h00);
    run(8, nu, nf);
    check("mid_pre2_outs", outs, 7'h00);
    check("mid_pre2_upd", nu, 0);
    step(1);
    check("mid_outs", outs, 7'h20);
    check("mid_upd", upd, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
